// File: rtl/digdug_vram_arbiter.sv
// Time-slotted arbiter that shares one synchronous video RAM between the tile scanner and the CPU.
// P=0/1 of every 8-phase pixel belong to the video fetch unless vertical blank frees them.
module digdug_vram_arbiter (
   input  logic       CLK48M,
   input  logic       RESET,
   input  logic       VBLK,
   input  logic [9:0] VID_AD,
   output logic [7:0] VID_DT,
   input  logic       CPU_REQ,
   input  logic       CPU_WE,
   input  logic [9:0] CPU_AD,
   input  logic [7:0] CPU_DI,
   output logic [7:0] CPU_DO,
   output logic       CPU_ACK,
   output logic [9:0] RAM_AD,
   output logic       RAM_WE,
   output logic [7:0] RAM_DI,
   input  logic [7:0] RAM_DO
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] CAPT  = 2'd2;
   localparam logic [1:0] ACK   = 2'd3;

   logic [2:0] phase;
   logic [2:0] phase_next;
   logic [1:0] state;
   logic [1:0] state_next;
   logic [9:0] lat_ad;
   logic       lat_we;
   logic [7:0] lat_di;
   logic       permit;
   logic       ack_q;
   logic [7:0] vid_q;
   logic [7:0] cpu_q;

   // The ISSUE cycle is the phase after the IDLE decision, so it must land in 2..7 unless blanking.
   assign phase_next = phase + 3'd1;
   assign permit     = VBLK || (phase_next >= 3'd2);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (CPU_REQ && permit) state_next = ISSUE;
         ISSUE:   state_next = lat_we ? ACK : CAPT;
         CAPT:    state_next = ACK;
         ACK:     if (!CPU_REQ) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         phase  <= 3'd0;
         state  <= IDLE;
         ack_q  <= 1'b0;
         lat_ad <= 10'd0;
         lat_we <= 1'b0;
         lat_di <= 8'd0;
         cpu_q  <= 8'd0;
         vid_q  <= 8'd0;
      end else begin
         phase <= phase_next;
         state <= state_next;
         ack_q <= (state_next == ACK);
         if (state == IDLE && state_next == ISSUE) begin
            lat_ad <= CPU_AD;
            lat_we <= CPU_WE;
            lat_di <= CPU_DI;
         end
         if (state == CAPT) cpu_q <= RAM_DO;
         // RAM_DO during P=1 holds the word addressed by VID_AD at P=0.
         if (phase == 3'd1 && !VBLK) vid_q <= RAM_DO;
      end
   end

   assign RAM_AD  = (state == ISSUE) ? lat_ad : VID_AD;
   assign RAM_WE  = (state == ISSUE) && lat_we;
   assign RAM_DI  = lat_di;
   assign CPU_ACK = ack_q;
   assign CPU_DO  = cpu_q;
   assign VID_DT  = vid_q;

endmodule

// File: tb/tb_digdug_vram_arbiter.sv
// Directed bench for the VRAM arbiter: a synchronous RAM model plus a table of CPU transactions
// with hand-computed latencies, followed by latching and mid-transaction reset sequences.
module tb_digdug_vram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       vblk;
   logic [9:0] vid_ad;
   logic [7:0] vid_dt;
   logic       cpu_req;
   logic       cpu_we;
   logic [9:0] cpu_ad;
   logic [7:0] cpu_di;
   logic [7:0] cpu_do;
   logic       cpu_ack;
   logic [9:0] ram_ad;
   logic       ram_we;
   logic [7:0] ram_di;
   logic [7:0] ram_do;

   logic [7:0] mem [0:1023];
   int         write_count = 0;
   logic [2:0] ph;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic       vblk;
      logic [2:0] start;
      logic       we;
      logic [9:0] ad;
      logic [7:0] di;
      logic [9:0] vid_ad;
      int         lat;
      logic [7:0] exp_do;
      logic [7:0] exp_vid;
   } vec_t;

   vec_t vecs [7];

   digdug_vram_arbiter dut (
      .CLK48M (clk),
      .RESET  (rst),
      .VBLK   (vblk),
      .VID_AD (vid_ad),
      .VID_DT (vid_dt),
      .CPU_REQ(cpu_req),
      .CPU_WE (cpu_we),
      .CPU_AD (cpu_ad),
      .CPU_DI (cpu_di),
      .CPU_DO (cpu_do),
      .CPU_ACK(cpu_ack),
      .RAM_AD (ram_ad),
      .RAM_WE (ram_we),
      .RAM_DI (ram_di),
      .RAM_DO (ram_do)
   );

   always #10 clk = ~clk;

   // Synchronous RAM: address sampled on the edge, data valid the following cycle.
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_ad] <= ram_di;
         write_count <= write_count + 1;
      end
      ram_do <= mem[ram_ad];
   end

   // Pixel phase reference, zero in the first cycle after reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) ph <= 3'd0;
      else     ph <= ph + 3'd1;
   end

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic wait_phase(input logic [2:0] target);
      int guard = 0;
      while (ph != target && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (ph != target) check_output("phase_wait_timeout", ph, target);
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      int n = 0;
      int wc0;
      wait_phase(v.start);
      vblk    = v.vblk;
      vid_ad  = v.vid_ad;
      cpu_we  = v.we;
      cpu_ad  = v.ad;
      cpu_di  = v.di;
      cpu_req = 1'b1;
      wc0     = write_count;
      while (!cpu_ack && n < 12) begin
         @(negedge clk);
         n++;
      end
      check_output($sformatf("v%0d_latency", idx), n, v.lat);
      if (v.we) begin
         check_output($sformatf("v%0d_write_count", idx), write_count - wc0, 1);
         check_output($sformatf("v%0d_mem", idx), mem[v.ad], v.di);
      end else begin
         check_output($sformatf("v%0d_no_write", idx), write_count - wc0, 0);
         check_output($sformatf("v%0d_cpu_do", idx), cpu_do, v.exp_do);
      end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      @(negedge clk);
      check_output($sformatf("v%0d_ack_drop", idx), cpu_ack, 0);
      wait_phase(3'd2);
      check_output($sformatf("v%0d_vid_dt", idx), vid_dt, v.exp_vid);
   endtask

   initial begin
      int wc_snap;
      int ack_seen;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h155] = 8'hA5;
      mem[10'h001] = 8'h7E;
      mem[10'h0F0] = 8'h5A;
      mem[10'h300] = 8'hC3;
      mem[10'h0AA] = 8'h11;

      vecs[0] = '{1'b0, 3'd0, 1'b0, 10'h001, 8'h00, 10'h155, 4, 8'h7E, 8'hA5};
      vecs[1] = '{1'b0, 3'd6, 1'b0, 10'h0F0, 8'h00, 10'h155, 3, 8'h5A, 8'hA5};
      vecs[2] = '{1'b0, 3'd7, 1'b1, 10'h2AB, 8'h99, 10'h155, 4, 8'h00, 8'hA5};
      vecs[3] = '{1'b1, 3'd0, 1'b0, 10'h300, 8'h00, 10'h0AA, 3, 8'hC3, 8'hA5};
      vecs[4] = '{1'b0, 3'd1, 1'b0, 10'h2AA, 8'h00, 10'h0AA, 3, 8'h3C, 8'h11};
      vecs[5] = '{1'b1, 3'd7, 1'b1, 10'h010, 8'h42, 10'h155, 2, 8'h00, 8'h11};
      vecs[6] = '{1'b0, 3'd2, 1'b0, 10'h010, 8'h00, 10'h155, 3, 8'h42, 8'hA5};

      rst = 1'b1; vblk = 1'b0; vid_ad = 10'h155;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_ad = 10'h0; cpu_di = 8'h0;
      repeat (3) @(negedge clk);
      check_output("rst_ack", cpu_ack, 0);
      check_output("rst_cpu_do", cpu_do, 8'h00);
      check_output("rst_vid_dt", vid_dt, 8'h00);
      check_output("rst_ram_we", ram_we, 0);
      check_output("rst_ram_di", ram_di, 8'h00);
      rst = 1'b0;

      // Plain video fetch: data appears after the edge ending P=1, no writes.
      wait_phase(3'd2);
      check_output("video_vid_dt", vid_dt, 8'hA5);
      check_output("video_no_write", write_count, 0);

      // Write at P=3 with inputs disturbed during ISSUE to prove they were latched.
      wait_phase(3'd3);
      cpu_we = 1'b1; cpu_ad = 10'h2AA; cpu_di = 8'h3C; cpu_req = 1'b1;
      @(negedge clk);
      check_output("wr_issue_we", ram_we, 1);
      check_output("wr_issue_ad", ram_ad, 10'h2AA);
      check_output("wr_issue_di", ram_di, 8'h3C);
      cpu_we = 1'b0; cpu_ad = 10'h155; cpu_di = 8'hFF;
      @(negedge clk);
      check_output("wr_ack", cpu_ack, 1);
      check_output("wr_we_low", ram_we, 0);
      @(negedge clk);
      check_output("wr_ack_held", cpu_ack, 1);
      cpu_req = 1'b0;
      @(negedge clk);
      check_output("wr_ack_drop", cpu_ack, 0);
      check_output("wr_count", write_count, 1);
      check_output("wr_mem", mem[10'h2AA], 8'h3C);
      check_output("wr_vid_untouched", mem[10'h155], 8'hA5);

      for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

      // Reset asserted while a write sits in ISSUE.
      wait_phase(3'd3);
      vblk = 1'b0;
      cpu_we = 1'b1; cpu_ad = 10'h020; cpu_di = 8'h77; cpu_req = 1'b1;
      @(negedge clk);
      check_output("rstmid_issue_we", ram_we, 1);
      wc_snap = write_count;
      rst = 1'b1;
      #1;
      check_output("rstmid_ram_we", ram_we, 0);
      check_output("rstmid_ack", cpu_ack, 0);
      check_output("rstmid_cpu_do", cpu_do, 8'h00);
      check_output("rstmid_vid_dt", vid_dt, 8'h00);
      check_output("rstmid_ram_di", ram_di, 8'h00);
      cpu_req = 1'b0; cpu_we = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ack_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (cpu_ack) ack_seen++;
      end
      check_output("rstmid_no_ack", ack_seen, 0);
      check_output("rstmid_no_write", write_count - wc_snap, 0);
      check_output("rstmid_mem", mem[10'h020], 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
